// File: rtl/rf_access_arbiter_if.sv
// Bundle of both master command/response ports plus the register-file access port.
// slave = arbiter side, master = environment side.
interface rf_access_arbiter_if #(
  parameter int Data_width    = 8,
  parameter int Address_width = 4
);
  logic                     M0_req, M0_wr, M0_gnt, M0_rvalid, M0_err;
  logic [Address_width-1:0] M0_addr;
  logic [Data_width-1:0]    M0_wdata, M0_rdata;
  logic                     M1_req, M1_wr, M1_gnt, M1_rvalid, M1_err;
  logic [Address_width-1:0] M1_addr;
  logic [Data_width-1:0]    M1_wdata, M1_rdata;
  logic                     WrEN, RdEN, RdData_valid, busy;
  logic [Address_width-1:0] Address;
  logic [Data_width-1:0]    WrData, Rd_data;

  modport slave (
    input  M0_req, M0_wr, M0_addr, M0_wdata, M1_req, M1_wr, M1_addr, M1_wdata,
           Rd_data, RdData_valid,
    output M0_gnt, M0_rdata, M0_rvalid, M0_err, M1_gnt, M1_rdata, M1_rvalid, M1_err,
           WrEN, RdEN, Address, WrData, busy
  );
  modport master (
    output M0_req, M0_wr, M0_addr, M0_wdata, M1_req, M1_wr, M1_addr, M1_wdata,
           Rd_data, RdData_valid,
    input  M0_gnt, M0_rdata, M0_rvalid, M0_err, M1_gnt, M1_rdata, M1_rvalid, M1_err,
           WrEN, RdEN, Address, WrData, busy
  );
endinterface

// File: rtl/rf_access_arbiter.sv
// Round-robin two-master arbiter onto a single register-file port; one access in
// flight, read data routed back to the owner with a timeout on missing RdData_valid.
module rf_access_arbiter #(
  parameter int Data_width    = 8,
  parameter int Address_width = 4,
  parameter int TIMEOUT       = 16
) (
  input logic                CLK,
  input logic                RST,
  rf_access_arbiter_if.slave bus
);
  localparam int DW = Data_width;
  localparam int AW = Address_width;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_t;

  logic [1:0]         req, wr;
  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] wdata;

  assign req   = {bus.M1_req,   bus.M0_req};
  assign wr    = {bus.M1_wr,    bus.M0_wr};
  assign addr  = {bus.M1_addr,  bus.M0_addr};
  assign wdata = {bus.M1_wdata, bus.M0_wdata};

  state_t             state;
  logic               ptr, owner, lat_wr, wren, rden, busy;
  logic [CW-1:0]      cnt;
  logic [AW-1:0]      addr_q;
  logic [DW-1:0]      wdata_q;
  logic [1:0]         gnt, rvalid, err;
  logic [1:0][DW-1:0] rdata;
  logic               win;

  // Contention goes to the pointer; otherwise the sole requester wins.
  assign win = (req[0] & req[1]) ? ptr : req[1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      owner   <= 1'b0;
      lat_wr  <= 1'b0;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wren    <= 1'b0;
      rden    <= 1'b0;
      busy    <= 1'b0;
      gnt     <= '0;
      rvalid  <= '0;
      err     <= '0;
      rdata   <= '0;
    end else begin
      gnt    <= '0;
      rvalid <= '0;
      err    <= '0;
      wren   <= 1'b0;
      rden   <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          owner    <= win;
          lat_wr   <= wr[win];
          addr_q   <= addr[win];
          wdata_q  <= wdata[win];
          gnt[win] <= 1'b1;
          wren     <= wr[win];
          rden     <= ~wr[win];
          busy     <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          ptr <= ~owner;
          cnt <= '0;
          if (lat_wr) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Response flags are registered here so they are visible during RESP.
          if (bus.RdData_valid) begin
            rdata[owner]  <= bus.Rd_data;
            rvalid[owner] <= 1'b1;
            state         <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rdata[owner]  <= '0;
            rvalid[owner] <= 1'b1;
            err[owner]    <= 1'b1;
            state         <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.M0_gnt    = gnt[0];
  assign bus.M1_gnt    = gnt[1];
  assign bus.M0_rvalid = rvalid[0];
  assign bus.M1_rvalid = rvalid[1];
  assign bus.M0_err    = err[0];
  assign bus.M1_err    = err[1];
  assign bus.M0_rdata  = rdata[0];
  assign bus.M1_rdata  = rdata[1];
  assign bus.WrEN      = wren;
  assign bus.RdEN      = rden;
  assign bus.Address   = addr_q;
  assign bus.WrData    = wdata_q;
  assign bus.busy      = busy;
endmodule
